// File: rtl/datapath_mc_pkg.sv
// Shared types for the multi-cycle datapath: ALU operation codes, FSM
// states and a small decode helper used by the top level.
package datapath_mc_pkg;

  localparam int ALUF_W = 4;

  typedef enum logic [ALUF_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True for the three shift operations (iterative when shamt > 0).
  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative ALU engine: holds latched operands, destination and step
// counter; advances one shift bit or one shift-add multiply step per cycle.
// res_o is the value produced by the step taken this cycle, so on the step
// where last_o is high it is the final result to write back.
module alu_iter
  import datapath_mc_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int RW    = 5,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  alu_op_e          op_i,
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  input  logic [CW-1:0]    cnt_i,
  input  logic [RW-1:0]    rd_i,
  input  logic             we_i,
  output logic [NBITS-1:0] res_o,
  output logic             last_o,
  output logic [RW-1:0]    rd_o,
  output logic             we_o
);

  // mcand_q is the shifted operand for shifts and the multiplicand for MUL.
  logic [NBITS-1:0] mcand_q;
  logic [NBITS-1:0] mplier_q;
  logic [NBITS-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  alu_op_e          op_q;
  logic [RW-1:0]    rd_q;
  logic             we_q;

  logic [NBITS-1:0] shift_d;
  logic [NBITS-1:0] addend;

  // One-bit shift of the working operand; MUL shifts its multiplicand left.
  always_comb begin
    shift_d = {mcand_q[NBITS-2:0], 1'b0};
    case (op_q)
      OP_SRL:  shift_d = {1'b0, mcand_q[NBITS-1:1]};
      OP_SRA:  shift_d = {mcand_q[NBITS-1], mcand_q[NBITS-1:1]};
      default: shift_d = {mcand_q[NBITS-2:0], 1'b0};
    endcase
  end

  assign addend = mplier_q[0] ? mcand_q : '0;
  assign res_o  = (op_q == OP_MUL) ? (acc_q + addend) : shift_d;
  assign last_o = (cnt_q == CW'(1));
  assign rd_o   = rd_q;
  assign we_o   = we_q;

  // Operand latch on load, one iteration per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= cnt_i;
      op_q     <= op_i;
      rd_q     <= rd_i;
      we_q     <= we_i;
    end else if (step_i) begin
      cnt_q   <= cnt_q - CW'(1);
      mcand_q <= shift_d;
      if (op_q == OP_MUL) begin
        acc_q    <= acc_q + addend;
        mplier_q <= {1'b0, mplier_q[NBITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, single-cycle ALU, write-back mux,
// registered flags and the IDLE/RUN controller for iterative shifts/MUL.
// Handshake: an operation is accepted on a rising edge where Start=1 and
// Busy=0; Busy is high while an iterative op runs; Done pulses for one
// cycle after every write-back edge. Start while Busy=1 is ignored.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = ALUF_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] RS1,
  input  logic [$clog2(NREGS)-1:0] RS2,
  input  logic [$clog2(NREGS)-1:0] RD,
  input  logic [NBITS-1:0]         IMM,
  input  logic [WIDTH_ALUF-1:0]    ALUControl,
  input  logic                     ALUSrc,
  input  logic                     MemtoReg,
  input  logic                     RegWrite,
  input  logic                     link,
  input  logic [NBITS-1:0]         pclink,
  input  logic                     Start,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Zero,
  output logic                     Neg,
  output logic                     Carry,
  output logic [NBITS-1:0]         PCReg,
  output logic [NBITS-3:0]         Address,
  output logic [NBITS-1:0]         WriteData,
  input  logic [NBITS-1:0]         ReadData,
  output state_e                   dbg_state_o
);

  localparam int RW  = $clog2(NREGS);
  localparam int SHW = $clog2(NBITS);
  localparam int CW  = SHW + 1;

  logic [NBITS-1:0] regs_q [NREGS];

  state_e state_q;
  logic   busy_q, done_q, zero_q, neg_q, carry_q;

  alu_op_e          op;
  logic [NBITS-1:0] srca, srcb;
  logic [SHW-1:0]   shamt;
  logic [NBITS:0]   sum, diff;
  logic [NBITS-1:0] sc_res;
  logic             sc_carry;
  logic             multi, accept;

  logic [NBITS-1:0] it_res;
  logic             it_last, it_we;
  logic [RW-1:0]    it_rd;

  logic             sc_fire, it_fire, wb_fire, wb_en, wb_we;
  logic [RW-1:0]    wb_rd;
  logic [NBITS-1:0] wb_val, flag_res;

  // Register reads are purely combinational; no write bypass.
  assign srca      = regs_q[RS1];
  assign WriteData = regs_q[RS2];
  assign PCReg     = srca;
  assign srcb      = ALUSrc ? IMM : regs_q[RS2];
  assign shamt     = srcb[SHW-1:0];
  assign op        = alu_op_e'(ALUControl);
  assign sum       = {1'b0, srca} + {1'b0, srcb};
  assign diff      = {1'b0, srca} - {1'b0, srcb};

  // Single-cycle ALU; shifts here only cover shamt=0 (result is SrcA).
  always_comb begin
    sc_res   = sum[NBITS-1:0];
    sc_carry = 1'b0;
    case (op)
      OP_SUB: begin
        sc_res   = diff[NBITS-1:0];
        sc_carry = ~diff[NBITS];
      end
      OP_AND:  sc_res = srca & srcb;
      OP_OR:   sc_res = srca | srcb;
      OP_XOR:  sc_res = srca ^ srcb;
      OP_SRL, OP_SLL, OP_SRA: sc_res = srca;
      OP_SLT:  sc_res = {{(NBITS-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_SLTU: sc_res = {{(NBITS-1){1'b0}}, (srca < srcb)};
      default: begin
        sc_res   = sum[NBITS-1:0];
        sc_carry = sum[NBITS];
      end
    endcase
  end

  assign Address = sc_res[NBITS-1:2];
  assign multi   = (is_shift(op) && (shamt != '0)) || (op == OP_MUL);
  assign accept  = (state_q == IDLE) && Start;

  alu_iter #(
    .NBITS(NBITS),
    .RW   (RW),
    .CW   (CW)
  ) u_iter (
    .clk    (clock),
    .rst    (reset),
    .load_i (accept && multi),
    .step_i (state_q == RUN),
    .op_i   (op),
    .a_i    (srca),
    .b_i    (srcb),
    .cnt_i  ((op == OP_MUL) ? CW'(NBITS) : CW'(shamt)),
    .rd_i   (RD),
    .we_i   (RegWrite),
    .res_o  (it_res),
    .last_o (it_last),
    .rd_o   (it_rd),
    .we_o   (it_we)
  );

  // Write-back selection: link and MemtoReg only affect single-cycle ops.
  always_comb begin
    sc_fire  = accept && !multi;
    it_fire  = (state_q == RUN) && it_last;
    wb_fire  = sc_fire || it_fire;
    wb_val   = it_res;
    wb_rd    = it_rd;
    wb_we    = it_we;
    flag_res = it_res;
    if (sc_fire) begin
      wb_rd    = RD;
      wb_we    = RegWrite;
      flag_res = sc_res;
      if (link)          wb_val = pclink;
      else if (MemtoReg) wb_val = ReadData;
      else               wb_val = sc_res;
    end
    wb_en = wb_fire && wb_we && (wb_rd != '0);
  end

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_rd] <= wb_val;
    end
  end

  // Controller FSM with registered Busy, Done and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      done_q <= wb_fire;
      if (wb_fire) begin
        zero_q  <= (flag_res == '0);
        neg_q   <= flag_res[NBITS-1];
        carry_q <= sc_fire ? sc_carry : 1'b0;
      end
      case (state_q)
        IDLE: if (accept && multi) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (it_last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Zero        = zero_q;
  assign Neg         = neg_q;
  assign Carry       = carry_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: table of issued operations with
// hand-computed results, then sequences for reset, busy-Start, back-to-back
// issue, no-bypass reads and mid-run reset.
module tb_datapath_mc;
  import datapath_mc_pkg::*;

  logic       clock, reset;
  logic [4:0] RS1, RS2, RD;
  logic [7:0] IMM, pclink, ReadData;
  logic [3:0] ALUControl;
  logic       ALUSrc, MemtoReg, RegWrite, link, Start;
  logic       Busy, Done, Zero, Neg, Carry;
  logic [7:0] PCReg, WriteData;
  logic [5:0] Address;
  state_e     dbg_state;

  int total = 0;
  int bad   = 0;

  datapath_mc #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock(clock), .reset(reset), .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .link(link), .pclink(pclink), .Start(Start),
    .Busy(Busy), .Done(Done), .Zero(Zero), .Neg(Neg), .Carry(Carry),
    .PCReg(PCReg), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic [3:0] ctl;
    logic       src, m2r, we, lnk;
    logic [7:0] pcl, rdata;
    int         cyc;
    logic [7:0] exp_reg;
    logic       z, n, c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [4:0] rs1, rs2, rd, input logic [7:0] imm,
                      input logic [3:0] ctl, input logic src, m2r, we, lnk,
                      input logic [7:0] pcl, rdata, input int cyc,
                      input logic [7:0] exp_reg, input logic z, n, c);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.ctl = ctl;
    v.src = src; v.m2r = m2r; v.we = we; v.lnk = lnk; v.pcl = pcl;
    v.rdata = rdata; v.cyc = cyc; v.exp_reg = exp_reg; v.z = z; v.n = n; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic [7:0] imm,
                       input logic [3:0] ctl, input logic src);
    RS1 = rs1; RS2 = rs2; RD = rd; IMM = imm; ALUControl = ctl; ALUSrc = src;
    MemtoReg = 1'b0; RegWrite = 1'b1; link = 1'b0;
  endtask

  // Reads a register through PCReg (combinational read port)
  task automatic chk_reg(input string name, input logic [4:0] r, input logic [7:0] exp);
    RS1 = r;
    #1 chk(name, PCReg, exp);
  endtask

  // Driver: issue one op, wait (bounded) for Done, check timing, flags, result
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen;
    @(negedge clock);
    RS1 = v.rs1; RS2 = v.rs2; RD = v.rd; IMM = v.imm; ALUControl = v.ctl;
    ALUSrc = v.src; MemtoReg = v.m2r; RegWrite = v.we; link = v.lnk;
    pclink = v.pcl; ReadData = v.rdata; Start = 1'b1;
    @(posedge clock);
    #1 Start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (Done) seen = 1'b1;
      else if (Busy) cyc++;
    end
    chk($sformatf("v%0d_done", idx), {31'd0, seen}, 32'd1);
    chk($sformatf("v%0d_busy_cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d_busy_at_done", idx), {31'd0, Busy}, 32'd0);
    chk($sformatf("v%0d_flags", idx), {29'd0, Zero, Neg, Carry}, {29'd0, v.z, v.n, v.c});
    chk_reg($sformatf("v%0d_reg", idx), v.rd, v.exp_reg);
    @(negedge clock);
    chk($sformatf("v%0d_done_pulse", idx), {31'd0, Done}, 32'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    Start = 1'b0; pclink = '0; ReadData = '0;
    drive(5'd0, 5'd0, 5'd0, 8'h00, 4'd0, 1'b0);

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_flags", {29'd0, Zero, Neg, Carry}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    for (int i = 0; i < 32; i++) chk_reg($sformatf("rst_x%0d", i), 5'(i), 8'h00);

    // rs1 rs2 rd imm ctl src m2r we lnk pcl rdata cyc exp z n c
    addv(0, 0, 1, 8'h05, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h05, 0, 0, 0);
    addv(1, 0, 2, 8'h05, 4'h1, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1);
    addv(0, 0, 3, 8'hFF, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 0, 1, 0);
    addv(3, 0, 4, 8'h01, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 1);
    addv(0, 0, 7, 8'hF0, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'hF0, 0, 1, 0);
    addv(7, 0, 8, 8'h03, 4'h5, 1, 0, 1, 0, 0, 0, 3, 8'h1E, 0, 0, 0);
    addv(0, 0, 9, 8'h80, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h80, 0, 1, 0);
    addv(9, 0, 10, 8'h02, 4'h7, 1, 0, 1, 0, 0, 0, 2, 8'hE0, 0, 1, 0);
    addv(0, 0, 11, 8'h01, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    addv(11, 0, 12, 8'h07, 4'h6, 1, 0, 1, 0, 0, 0, 7, 8'h80, 0, 1, 0);
    addv(7, 0, 13, 8'h08, 4'h6, 1, 0, 1, 0, 0, 0, 0, 8'hF0, 0, 1, 0);
    addv(0, 0, 14, 8'h0D, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h0D, 0, 0, 0);
    addv(0, 0, 15, 8'h0B, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h0B, 0, 0, 0);
    addv(14, 15, 16, 8'h00, 4'hA, 0, 0, 1, 0, 0, 0, 8, 8'h8F, 0, 1, 0);
    addv(0, 0, 17, 8'h14, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h14, 0, 0, 0);
    addv(17, 17, 18, 8'h00, 4'hA, 0, 0, 1, 0, 0, 0, 8, 8'h90, 0, 1, 0);
    addv(3, 0, 19, 8'h01, 4'h8, 1, 0, 1, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    addv(3, 0, 20, 8'h01, 4'h9, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0);
    addv(3, 0, 0, 8'h00, 4'h0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    addv(7, 0, 21, 8'h3C, 4'h2, 1, 0, 1, 0, 0, 0, 0, 8'h30, 0, 0, 0);
    addv(7, 0, 22, 8'h0F, 4'h3, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 0, 1, 0);
    addv(7, 0, 23, 8'hFF, 4'h4, 1, 0, 1, 0, 0, 0, 0, 8'h0F, 0, 0, 0);
    addv(0, 0, 5, 8'h00, 4'h0, 1, 0, 1, 1, 8'h40, 0, 0, 8'h40, 1, 0, 0);
    addv(0, 0, 6, 8'h00, 4'h0, 1, 1, 1, 0, 0, 8'hA5, 0, 8'hA5, 1, 0, 0);
    addv(0, 0, 24, 8'h07, 4'h0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    addv(11, 11, 25, 8'h00, 4'hF, 0, 0, 1, 0, 0, 0, 0, 8'h02, 0, 0, 0);
    addv(11, 3, 26, 8'h00, 4'h1, 0, 0, 1, 0, 0, 0, 0, 8'h02, 0, 0, 0);
    addv(3, 0, 27, 8'hFF, 4'hA, 1, 0, 1, 0, 0, 0, 8, 8'h01, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Combinational Address and WriteData
    @(negedge clock);
    drive(5'd1, 5'd6, 5'd0, 8'h0C, 4'h0, 1'b1);
    #1 chk("address", {26'd0, Address}, 32'h04);
    chk("writedata", {24'd0, WriteData}, 32'hA5);

    // No write bypass: read in the write-back cycle sees the old value
    @(negedge clock);
    drive(5'd28, 5'd0, 5'd28, 8'h33, 4'h0, 1'b1);
    Start = 1'b1;
    #1 chk("nobypass_old", {24'd0, PCReg}, 32'h00);
    @(posedge clock);
    #1 Start = 1'b0;
    chk("nobypass_new", {24'd0, PCReg}, 32'h33);

    // Start held during Busy is ignored
    @(negedge clock);
    drive(5'd14, 5'd15, 5'd30, 8'h00, 4'hA, 1'b0);
    Start = 1'b1;
    @(posedge clock);
    #1 drive(5'd0, 5'd0, 5'd29, 8'h55, 4'h0, 1'b1);
    repeat (3) @(posedge clock);
    #1 Start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (Done) dones++;
    end
    chk("busy_start_dones", dones, 1);
    chk_reg("busy_start_x29", 5'd29, 8'h00);
    chk_reg("busy_start_x30", 5'd30, 8'h8F);

    // Back-to-back: second Start in the Done cycle of the first
    @(negedge clock);
    drive(5'd0, 5'd0, 5'd31, 8'h01, 4'h0, 1'b1);
    Start = 1'b1;
    @(negedge clock);
    chk("b2b_done1", {31'd0, Done}, 32'd1);
    drive(5'd31, 5'd0, 5'd31, 8'h01, 4'h0, 1'b1);
    @(negedge clock);
    Start = 1'b0;
    chk("b2b_done2", {31'd0, Done}, 32'd1);
    chk_reg("b2b_x31", 5'd31, 8'h02);

    // Reset in the middle of a MUL
    @(negedge clock);
    drive(5'd14, 5'd15, 5'd16, 8'h00, 4'hA, 1'b0);
    Start = 1'b1;
    @(posedge clock);
    #1 Start = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrun_busy_before", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    #1 chk("midrun_busy_drop", {31'd0, Busy}, 32'd0);
    chk("midrun_state", {31'd0, dbg_state}, {31'd0, IDLE});
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (Done) dones++;
    end
    chk("midrun_no_done", dones, 0);
    chk_reg("midrun_x16", 5'd16, 8'h00);
    chk_reg("midrun_x14", 5'd14, 8'h00);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Multi-cycle successor to the single-cycle simulator datapath: a parametrised register file plus ALU with a full operation set, including iterative (one bit per cycle) shifts and a shift-add multiplier. It is driven by the controller through a Start/Busy/Done handshake. It sits between the controller, the PC logic (link/PCReg) and the data memory or cache port.

## Interface
- NBITS, 8, datapath and register width (≥4)
- NREGS, 32, register count (power of two); register 0 reads 0 and ignores writes
- WIDTH_ALUF, 4, ALUControl width
- Clocking: one clock; reset is asynchronous and active-high.
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- RS1, RS2, RD  in  $clog2(NREGS) each  source and destination register indices
- IMM  in  NBITS  signed immediate
- ALUControl  in  WIDTH_ALUF  operation code
- ALUSrc  in  1  SrcB = IMM (1) or reg[RS2] (0)
- MemtoReg  in  1  write back ReadData instead of ALU result
- RegWrite  in  1  enables write-back
- link  in  1  write back pclink (priority over MemtoReg)
- pclink  in  NBITS  return address from PC
- Start  in  1  request: the operation is sampled when Busy=0
- Busy  out  1  iterative operation in progress
- Done  out  1  one-cycle pulse after each write-back edge
- Zero, Neg, Carry  out  1 each  registered flags
- PCReg  out  NBITS  combinational reg[RS1]
- Address  out  NBITS-2  ALU result [NBITS-1:2], combinational
- WriteData  out  NBITS  combinational reg[RS2]
- ReadData  in  NBITS  memory read data

## Operation
- ALUControl codes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SRL; 0110 SLL; 0111 SRA.
  - 1000 SLT (signed, result 0/1); 1001 SLTU (unsigned, result 0/1).
  - 1010 MUL (low NBITS of the unsigned product).
  - All other codes execute as ADD.
- Shift amount shamt = SrcB[$clog2(NBITS)-1:0]. Upper bits of SrcB are ignored.
- FSM states IDLE and RUN:
  - IDLE, Start=1, single-cycle op: the write-back occurs at the same edge. Single-cycle ops are ADD, SUB, logic ops, SLT, SLTU, and shifts with shamt=0 (result SrcA). State stays IDLE.
  - IDLE, Start=1, shift with shamt>0 or MUL: latch SrcA, SrcB, RD, the write enable and the op. Load counter with shamt (shifts) or NBITS (MUL). Go to RUN.
  - RUN: each cycle performs one shift step or one multiply step (add multiplicand if the multiplier LSB is 1, then shift). The counter decrements. The step with counter=1 writes back and returns to IDLE.
- Write-back value priority: link → pclink; else MemtoReg → ReadData; else result.
  - Write-back happens only if RegWrite=1 and RD≠0.
  - link and MemtoReg apply only to single-cycle ops.
- Flags update at every write-back edge, including RD=0 or RegWrite=0:
  - Zero = (result == 0); Neg = result[NBITS-1].
  - Carry = carry-out for ADD; for SUB, Carry = no-borrow (SrcA ≥ SrcB unsigned); 0 for all other ops.
- Start while Busy=1 is ignored and has no later effect. Inputs other than Start are don't-care during RUN.
- Register reads (PCReg, WriteData, SrcA/SrcB) stay combinational in all states. There is no write bypass: a read in the write-back cycle sees the old value.

## Timing
- Reset values: all registers 0, state IDLE, Busy=0, Done=0, Zero=Neg=Carry=0.
- Reset is asynchronous at any time, including mid-RUN: the operation is abandoned and no Done is produced.
- Single-cycle op: Done=1 in the cycle after the Start edge.
- Shift with shamt=k>0: Busy=1 for k cycles, then Done=1 in the next cycle (Busy already 0).
- MUL: Busy=1 for NBITS cycles, then Done.
- Back-to-back issue: Start may be asserted in the same cycle as Done.
- Busy is registered and asserts the cycle after the accepting edge.

## Structure
- Package datapath_mc_pkg holds:
  - typedef enum alu_op_e with the codes above;
  - typedef enum state_e {IDLE, RUN};
  - ALU code width constant.
- Sub-module alu_iter: latched operands, counter, one-step shift/multiply logic, last-step indication. Top level holds the register file, single-cycle ALU, write-back mux, flags and FSM.

## Test plan
- Reset, then release → all 32 registers 0, Busy=0, Done=0, flags 0. Assert reset mid-MUL → Busy drops immediately, no Done pulse.
- ADD x1=x0+IMM 5 → Done next cycle, x1=0x05. Then SUB x2=x1-IMM 5 → x2=0x00, Zero=1, Carry=1. Then ADD 0xFF+0x01 → 0x00, Carry=1.
- SRL of 0xF0 by 3 → Busy 3 cycles, result 0x1E. SRA of 0x80 by 2 → 0xE0. SLL of 0x01 by 7 → 0x80, Neg=1. shamt=0 → completes single-cycle, result equals SrcA.
- MUL 13×11 → Busy 8 cycles, result 0x8F, Neg=1. MUL 20×20 → 0x90. Start pulsed during Busy → ignored, exactly one Done.
- SLT 0xFF vs 0x01 → 1. SLTU 0xFF vs 0x01 → 0. RD=0 write → x0 stays 0, but flags update.
- link with pclink=0x40, RD=5 → x5=0x40. MemtoReg with ReadData=0xA5, RD=6 → x6=0xA5. ADD x1+IMM 0x0C → Address=ALU result[7:2]=0x04 (x1=0x05 from the ADD scenario).
